btn_debounce_pulse: RTL and testbench

- Conditions a raw, bouncy, asynchronous push-button input into a clean debounced level and a single-cycle enable pulse.
- Sits directly upstream of the 8-bit up-counter: pulse drives the counter's EN, so each physical press advances the count by exactly 1.
- Used on the board top level between the button pin and the counter/display path.

---
 rtl/btn_debounce_pulse.sv | 163 ++++++++++++++++
 tb/tb_btn_debounce_pulse.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: synchronizes btn_in, debounces it into btn_level and emits a
// one-cycle pulse per accepted press. Define BTN_AUTO_REPEAT_EN for hold-to-repeat pulses.
module btn_debounce_pulse #(
  parameter int DEBOUNCE_CYCLES     = 1000000,
  parameter int SYNC_STAGES         = 2,
  parameter int REPEAT_DELAY_CYCLES = 50000000,
  parameter int REPEAT_RATE_CYCLES  = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic pulse
);

  localparam int MAX_AB     = (DEBOUNCE_CYCLES > REPEAT_DELAY_CYCLES) ? DEBOUNCE_CYCLES
                                                                      : REPEAT_DELAY_CYCLES;
  localparam int MAX_CYCLES = (MAX_AB > REPEAT_RATE_CYCLES) ? MAX_AB : REPEAT_RATE_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    CHK_PRESS,
    PRESSED,
    CHK_RELEASE
  } state_t;

  // ---------------------------------------------------------------- synchronizer
  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] sync_next;
  logic                   sync_btn;

  assign sync_next[0] = btn_in;

  generate
    for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
      assign sync_next[gi] = sync_reg[gi-1];
    end
  endgenerate

  assign sync_btn = sync_reg[SYNC_STAGES-1];

  // ---------------------------------------------------------------- debounce FSM
  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          level_reg, level_next;
  logic          pulse_reg, pulse_next;
  logic          rpt_fire;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pulse_next = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (sync_btn) begin
          state_next = CHK_PRESS;
        end
      end
      CHK_PRESS: begin
        if (!sync_btn) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == DEB_LAST) begin
          state_next = PRESSED;
          cnt_next   = '0;
          pulse_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      PRESSED: begin
        cnt_next = '0;
        if (!sync_btn) begin
          state_next = CHK_RELEASE;
        end else if (rpt_fire) begin
          pulse_next = 1'b1;
        end
      end
      CHK_RELEASE: begin
        if (sync_btn) begin
          // release bounce: back to the held state without a new pulse
          state_next = PRESSED;
          cnt_next   = '0;
        end else if (cnt_reg == DEB_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    level_next = (state_next == PRESSED) || (state_next == CHK_RELEASE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg  <= '0;
      state_reg <= IDLE;
      cnt_reg   <= '0;
      level_reg <= 1'b0;
      pulse_reg <= 1'b0;
    end else begin
      sync_reg  <= sync_next;
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      level_reg <= level_next;
      pulse_reg <= pulse_next;
    end
  end

  assign btn_level = level_reg;
  assign pulse     = pulse_reg;

  // ---------------------------------------------------------------- auto-repeat
`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [CW-1:0] RPT_DELAY_LAST = CW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [CW-1:0] RPT_RATE_LAST  = CW'(REPEAT_RATE_CYCLES - 1);

  logic [CW-1:0] rpt_cnt_reg, rpt_cnt_next;
  logic          rpt_armed_reg, rpt_armed_next;  // first repeat done, now pacing at RATE
  logic [CW-1:0] rpt_last;

  always_comb begin
    rpt_cnt_next   = rpt_cnt_reg;
    rpt_armed_next = rpt_armed_reg;
    rpt_fire       = 1'b0;
    rpt_last       = rpt_armed_reg ? RPT_RATE_LAST : RPT_DELAY_LAST;
    if ((state_reg == PRESSED) && sync_btn) begin
      if (rpt_cnt_reg == rpt_last) begin
        rpt_fire       = !pulse_reg;
        rpt_cnt_next   = '0;
        rpt_armed_next = 1'b1;
      end else begin
        rpt_cnt_next = rpt_cnt_reg + 1'b1;
      end
    end else if ((state_reg == IDLE) || (state_reg == CHK_PRESS)) begin
      // CHK_RELEASE (and a PRESSED cycle that is leaving) just hold the count
      rpt_cnt_next   = '0;
      rpt_armed_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rpt_cnt_reg   <= '0;
      rpt_armed_reg <= 1'b0;
    end else begin
      rpt_cnt_reg   <= rpt_cnt_next;
      rpt_armed_reg <= rpt_armed_next;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Scoreboard bench for btn_debounce_pulse: stimulus pushes expected pulse/level edge cycles,
// a negedge monitor pops and compares them as the outputs change.
module tb_btn_debounce_pulse;

  localparam int DEB   = 8;
  localparam int SYNC  = 2;
  localparam int RDLY  = 20;
  localparam int RRATE = 5;
  localparam int LAT   = SYNC + DEB + 1;

  typedef struct {
    logic val;
    int   cyc;
  } lvl_ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_in = 1'b0;
  logic btn_level;
  logic pulse;

  int        cyc = 0;
  int        checks = 0;
  int        errors = 0;
  int        exp_pulses = 0;
  logic [7:0] count8 = 8'd0;  // downstream up-counter model driven by pulse
  int        pulse_q[$];
  lvl_ev_t   level_q[$];

  btn_debounce_pulse #(
    .DEBOUNCE_CYCLES    (DEB),
    .SYNC_STAGES        (SYNC),
    .REPEAT_DELAY_CYCLES(RDLY),
    .REPEAT_RATE_CYCLES (RRATE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_in   (btn_in),
    .btn_level(btn_level),
    .pulse    (pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- monitor
  initial begin
    logic prev_level;
    logic prev_pulse;
    lvl_ev_t ev;
    int   exp_c;
    prev_level = 1'b0;
    prev_pulse = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        checks++;
        if (pulse !== 1'b0 || btn_level !== 1'b0) begin
          errors++;
          $display("FAIL reset_outputs cyc=%0d pulse=%b level=%b required 0/0", cyc, pulse, btn_level);
        end
      end else begin
        while (pulse_q.size() > 0 && pulse_q[0] < cyc) begin
          checks++;
          errors++;
          $display("FAIL missing_pulse expected at cyc=%0d not observed by cyc=%0d", pulse_q[0], cyc);
          void'(pulse_q.pop_front());
        end
        while (level_q.size() > 0 && level_q[0].cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL missing_level level->%b expected at cyc=%0d not seen by cyc=%0d",
                   level_q[0].val, level_q[0].cyc, cyc);
          void'(level_q.pop_front());
        end
        if (pulse === 1'b1) begin
          count8 = count8 + 8'd1;
          checks++;
          if (prev_pulse === 1'b1) begin
            errors++;
            $display("FAIL double_pulse pulse high two cycles at cyc=%0d", cyc);
          end else if (pulse_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse at cyc=%0d required none", cyc);
          end else begin
            exp_c = pulse_q.pop_front();
            if (exp_c != cyc) begin
              errors++;
              $display("FAIL pulse_time got cyc=%0d required cyc=%0d", cyc, exp_c);
            end
          end
        end
        if (btn_level !== prev_level) begin
          checks++;
          if (level_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_level level=%b at cyc=%0d required no change", btn_level, cyc);
          end else begin
            ev = level_q.pop_front();
            if (ev.val !== btn_level || ev.cyc != cyc) begin
              errors++;
              $display("FAIL level_edge got %b at cyc=%0d required %b at cyc=%0d",
                       btn_level, cyc, ev.val, ev.cyc);
            end
          end
        end
      end
      prev_level = btn_level;
      prev_pulse = pulse;
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic push_pulse(input int c);
    pulse_q.push_back(c);
    exp_pulses++;
  endtask

  task automatic push_level(input logic v, input int c);
    lvl_ev_t ev;
    ev.val = v;
    ev.cyc = c;
    level_q.push_back(ev);
  endtask

  // clean press: high for nh cycles, then low for nl cycles
  task automatic press(input int nh, input int nl);
    int c;
    int d;
    c = cyc;
    d = c + nh;
    btn_in = 1'b1;
    push_pulse(c + LAT);
    push_level(1'b1, c + LAT);
`ifdef BTN_AUTO_REPEAT_EN
    for (int e = c + LAT + RDLY; e <= d + 2; e += RRATE) push_pulse(e);
`endif
    tick(nh);
    btn_in = 1'b0;
    push_level(1'b0, cyc + LAT);
    tick(nl);
  endtask

  task automatic glitch(input int nh, input int nl);
    btn_in = 1'b1;
    tick(nh);
    btn_in = 1'b0;
    tick(nl);
  endtask

  initial begin
    int c;
    int r;
    #1 rst = 1'b0;
    tick(1);
    // reset held while the button chatters
    for (int i = 0; i < 6; i++) begin
      btn_in = ~btn_in;
      tick(1);
    end
    btn_in = 1'b0;
    rst    = 1'b1;
    tick(10);

    press(30, 20);

    // bouncy press then bouncy release
    for (int b = 0; b < 5; b++) glitch(3, 3);
    c = cyc;
    btn_in = 1'b1;
    push_pulse(c + LAT);
    push_level(1'b1, c + LAT);
    tick(20);
    for (int b = 0; b < 2; b++) begin
      btn_in = 1'b0;
      tick(2);
      btn_in = 1'b1;
      tick(2);
    end
    btn_in = 1'b0;
    push_level(1'b0, cyc + LAT);
    tick(20);

    // short glitches: 6 and 8 synchronized highs are rejected, 9 is accepted
    glitch(6, 15);
    glitch(8, 15);
    press(9, 15);

    // reset in the 7th CHK_PRESS cycle, released with the button still high
    btn_in = 1'b1;
    tick(9);
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    r = cyc;
    push_pulse(r + LAT);
    push_level(1'b1, r + LAT);
    tick(20);
    btn_in = 1'b0;
    push_level(1'b0, cyc + LAT);
    tick(15);

    // long hold: single pulse, or delayed repeats when auto-repeat is built in
    press(60, 20);
    tick(5);

    checks++;
    if (pulse_q.size() != 0) begin
      errors++;
      $display("FAIL pending_pulses got %0d outstanding required 0", pulse_q.size());
    end
    checks++;
    if (level_q.size() != 0) begin
      errors++;
      $display("FAIL pending_levels got %0d outstanding required 0", level_q.size());
    end
    checks++;
    if (count8 !== 8'(exp_pulses)) begin
      errors++;
      $display("FAIL counter_value got %0d required %0d", count8, exp_pulses);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog simulation time limit reached at cyc=%0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
